// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Resolves fetch/data-cache stalls, divider occupancy, load-use hazards,
// branch mispredicts and exceptions into per-stage stall (hold) and flush
// (bubble) controls. All controls are combinational. Only the wrong-path
// kill FSM and the two event counters are registered.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_stall           fetch busy
//   d_stall           D-cache busy (owned by M)
//   div_busyE         divider running for the instruction in E
//   load_useE         load in E feeds the instruction in D
//   mispredictE       branch in E resolved against its prediction
//   exceptionM        exception/eret committing in M
//   stallF..stallW    hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   flushD..flushW    bubble into IF/ID, ID/EX, EX/MEM, MEM/WB
//   kill_pend         a wrong-path fetch is in flight; discard its result
//   stall_cnt         cycles with any stall asserted (wraps)
//   flush_cnt         redirect events, exception or mispredict (wraps)
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        d_stall,
  input  logic        div_busyE,
  input  logic        load_useE,
  input  logic        mispredictE,
  input  logic        exceptionM,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        stallW,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        kill_pend,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {RUN, KILL} state_t;
  state_t state;

  logic excEvt;   // exception redirect taken this cycle
  logic mispEvt;  // mispredict redirect taken this cycle
  logic anyStall;

  assign kill_pend = (state == KILL);
  assign anyStall  = stallF | stallD | stallE | stallM | stallW;

  // First matching rule wins. Ordering matters:
  //  - an exception waits for its own D-cache access (d_stall) to finish,
  //    but overrides a fetch stall; the abandoned fetch is then killed
  //    via the KILL state.
  //  - a pending kill with fetch still busy only holds the PC and keeps
  //    bubbling IF/ID so the older stages drain underneath it.
  //  - a mispredict only redirects once E is free to move.
  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    stallM  = 1'b0;
    stallW  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    flushW  = 1'b0;
    excEvt  = 1'b0;
    mispEvt = 1'b0;
    if (exceptionM && !d_stall) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
      excEvt = 1'b1;
    end else if (kill_pend && i_stall) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end else if (i_stall || d_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else if (div_busyE) begin
      // E holds on the divider; M receives bubbles meanwhile.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (mispredictE) begin
      // Delay slot in D advances; only the wrong-path fetch in F is dropped.
      flushD  = 1'b1;
      mispEvt = 1'b1;
    end else if (load_useE) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (kill_pend) begin
      // Wrong-path instruction has just returned; drop it.
      flushD = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      case (state)
        RUN:  if (excEvt && i_stall) state <= KILL;
        KILL: begin
          // A fresh exception behind a still-busy fetch re-arms the kill.
          if (excEvt && i_stall) state <= KILL;
          else if (!i_stall)     state <= RUN;
        end
        default: state <= RUN;
      endcase
      if (anyStall)          stall_cnt <= stall_cnt + 32'd1;
      if (excEvt || mispEvt) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on the rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: i_stall  in  1  I-cache/fetch busy.
REQ-004 SHALL have port: d_stall  in  1  D-cache busy, access owned by the instruction in M.
REQ-005 SHALL have port: div_busyE  in  1  multi-cycle divider still running for the instruction in E.
REQ-006 SHALL have port: load_useE  in  1  load in E writes a register that the instruction in D reads.
REQ-007 SHALL have port: mispredictE  in  1  branch resolved in E disagrees with the prediction; held while E is stalled.
REQ-008 SHALL have port: exceptionM  in  1  exception or eret committed in M; held while M is stalled.
REQ-009 SHALL have ports: stallF, stallD, stallE, stallM, stallW  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB respectively.
REQ-010 SHALL have ports: flushD, flushE, flushM, flushW  out  1 each  load a bubble into IF/ID, ID/EX, EX/MEM, MEM/WB at the next edge.
REQ-011 SHALL have port: kill_pend  out  1  a wrong-path fetch is in flight and its result must be discarded.
REQ-012 SHALL have port: stall_cnt  out  32  count of cycles with any stall output high.
REQ-013 SHALL have port: flush_cnt  out  32  count of redirect events (exception or mispredict).

Function
REQ-014 SHALL compute stall and flush outputs combinationally from the inputs and kill_pend, using the first matching rule of REQ-015 to REQ-021; unlisted outputs are 0.
REQ-015 P1: exceptionM & ~d_stall -> flushD = flushE = flushM = flushW = 1; all stalls 0, even if i_stall = 1; this is an exception event.
REQ-016 P2: kill_pend & i_stall -> stallF = 1, flushD = 1; stallD/E/M/W = 0, so older stages drain.
REQ-017 P3: i_stall | d_stall -> all five stalls = 1.
REQ-018 P4: div_busyE -> stallF = stallD = stallE = 1, flushM = 1.
REQ-019 P5: mispredictE -> flushD = 1, discarding the wrong-path instruction in F; the delay slot in D advances. This is a mispredict event.
REQ-020 P6: load_useE -> stallF = stallD = 1, flushE = 1.
REQ-021 P7: kill_pend & ~i_stall -> flushD = 1, discarding the returned wrong-path instruction.
REQ-022 SHALL implement a 2-state FSM {RUN, KILL}; kill_pend = (state == KILL).
REQ-023 RUN -> KILL when an exception event occurs with i_stall = 1.
REQ-024 KILL -> RUN in the first cycle with i_stall = 0 (P7 cycle), unless REQ-025 applies.
REQ-025 Exception event with i_stall = 1 while in KILL -> remain in KILL.
REQ-026 stall_cnt SHALL increment by 1 in every cycle with any stall output = 1; flush_cnt SHALL increment by 1 per exception or mispredict event.
REQ-027 Each counter SHALL increment by at most 1 per cycle and wrap 0xFFFFFFFF -> 0.
REQ-028 Outputs SHALL have zero latency from the inputs; only the state and the counters are registered.

Reset
REQ-029 With rst = 1 at an edge: state <- RUN, stall_cnt <- 0, flush_cnt <- 0; counters and FSM do not update that cycle.
REQ-030 During rst, stall/flush outputs follow REQ-014 with kill_pend = 0 after the edge; reset mid-KILL SHALL abandon the pending discard.

Verification
REQ-031 load_useE = 1 for 1 cycle, others 0 -> stallF = stallD = 1, flushE = 1; stall_cnt 0 -> 1.
REQ-032 d_stall = 1 for 3 cycles with mispredictE = 1 -> all stalls 1 for 3 cycles; then 1 cycle of flushD = 1; flush_cnt += 1; stall_cnt += 3.
REQ-033 exceptionM = 1 with i_stall = 1, then i_stall high 2 more cycles -> cycle 0 all four flushes, kill_pend = 1; cycles 1-2 stallF = 1, flushD = 1; cycle 3 (i_stall = 0) flushD = 1, then kill_pend = 0.
REQ-034 div_busyE = 1 for 5 cycles with load_useE = 1 -> P4 outputs for 5 cycles, flushE = 0 throughout.
REQ-035 Preload stall_cnt = 0xFFFFFFFE via 2^32 − 2 stall cycles (or force), then 3 stall cycles -> 0xFFFFFFFF, 0x0, 0x1.
REQ-036 rst = 1 while in KILL with counters nonzero -> next cycle kill_pend = 0, stall_cnt = flush_cnt = 0.
